// File: rtl/rbz_spi_pkg.sv
// rbz_spi_pkg: shared types and constants for the raybox-zero SPI register transmitter
package rbz_spi_pkg;

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, GAP} state_t;

    localparam int DEF_DATA_W = 74;
    localparam int DEF_LEN_W  = 7;

    localparam logic [DEF_LEN_W-1:0] REG_FRAME_LEN = 7'd28;
    localparam logic [DEF_LEN_W-1:0] VEC_FRAME_LEN = 7'd74;

endpackage

// File: rtl/rbz_spi_halfdiv.sv
// rbz_spi_halfdiv: half-period down-counter, restartable, ticking on the last cycle of each phase
module rbz_spi_halfdiv #(
    parameter logic [7:0] RELOAD = 8'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic phase_end,
    output logic phase_end_next
);

    logic [7:0] cnt, cnt_n;

    // restart on load, otherwise count down and wrap back to the reload value
    always_comb begin
        cnt_n = load ? RELOAD : (cnt == 8'd0 ? RELOAD : cnt - 8'd1);
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) cnt <= RELOAD;
        else     cnt <= cnt_n;
    end

    assign phase_end      = cnt == 8'd0;
    assign phase_end_next = cnt_n == 8'd0;

endmodule

// File: rtl/rbz_spi_reg_tx.sv
// rbz_spi_reg_tx: SPI mode-0 frame transmitter feeding the raybox-zero register/vector slave
module rbz_spi_reg_tx
    import rbz_spi_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int HALF_DIV = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_ready,
    output logic              o_done,
    output logic              o_csb,
    output logic              o_sclk,
    output logic              o_mosi
);

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [LEN_W-1:0]  bitcnt, bitcnt_n, eff_len;
    logic              accept, done_n, active_n, phase_end, phase_end_next;

    assign accept  = i_start && o_ready;
    assign eff_len = (i_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_len;

    rbz_spi_halfdiv #(.RELOAD(8'(HALF_DIV - 1))) u_halfdiv (
        .clk           (i_clk),
        .rst           (i_reset),
        .load          (accept),
        .phase_end     (phase_end),
        .phase_end_next(phase_end_next)
    );

    // next state, shifter and bit counter; outputs are derived from the next state so they register in step
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        bitcnt_n = bitcnt;
        done_n   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                bitcnt_n = eff_len;
                shreg_n  = i_data << (LEN_W'(DATA_W) - eff_len);
                state_n  = (eff_len == '0) ? IDLE : LEAD;
                done_n   = eff_len == '0;
            end
            LEAD: if (phase_end) state_n = HIGH;
            HIGH: if (phase_end) begin
                state_n  = LOW;
                bitcnt_n = bitcnt - LEN_W'(1);
                if (bitcnt > LEN_W'(1)) shreg_n = shreg << 1;
            end
            LOW:  if (phase_end) state_n = (bitcnt == '0) ? GAP : HIGH;
            GAP:  if (phase_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        done_n   = done_n || (state_n == GAP && phase_end_next);
        active_n = state_n == LEAD || state_n == HIGH || state_n == LOW;
    end

    // state and registered SPI/handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            o_ready <= 1'b1;
            o_done  <= 1'b0;
            o_csb   <= 1'b1;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            o_ready <= state_n == IDLE && !done_n;
            o_done  <= done_n;
            o_csb   <= !active_n;
            o_sclk  <= state_n == HIGH;
            o_mosi  <= active_n && shreg_n[DATA_W-1];
        end
    end

endmodule

// File: tb/tb_rbz_spi_reg_tx.sv
// tb_rbz_spi_reg_tx: two transmitters (H=2 and H=1) checked against frame timing and a capturing slave
module tb_rbz_spi_reg_tx;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [73:0] i_data = '0;
    logic [6:0]  i_len = '0;
    logic        ready[2], done[2], csb[2], sclk[2], mosi[2];
    int          checks = 0;
    int          errors = 0;

    always #5 i_clk = ~i_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rbz_spi_reg_tx #(.DATA_W(74), .LEN_W(7), .HALF_DIV(g == 0 ? 2 : 1)) u_dut (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_start(i_start),
            .i_data (i_data),
            .i_len  (i_len),
            .o_ready(ready[g]),
            .o_done (done[g]),
            .o_csb  (csb[g]),
            .o_sclk (sclk[g]),
            .o_mosi (mosi[g])
        );
    end

    function automatic int hv(input int g);
        return g == 0 ? 2 : 1;
    endfunction

    function automatic logic [73:0] rnd74();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[73:0];
    endfunction

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [73:0] obs, input logic [73:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int outs(input int g);
        return int'({csb[g], sclk[g], mosi[g], ready[g], done[g]});
    endfunction

    task automatic run_frame(input string tag, input logic [73:0] data, input logic [6:0] len,
                             input bit hold, input int poke, input int rst_at);
        int eff, lim, h, wait_n, dexp;
        logic [73:0] expw;
        int first_low[2], last_low[2], low_cnt[2], idle_bad[2], rise_bad[2], nbits[2];
        int done_cnt[2], done_all[2], done_cyc[2], ready_back[2], next_low[2];
        bit ended[2], prev_sclk[2];
        logic [73:0] cap[2];
        eff = (len > 7'd74) ? 74 : int'(len);
        expw = '0;
        for (int j = 0; j < eff; j++) expw[j] = data[j];
        wait_n = 0;
        while (!(ready[0] && ready[1]) && wait_n < 400) begin
            tick();
            wait_n++;
        end
        check_i({tag, " ready_wait"}, int'(ready[0] && ready[1]), 1);
        for (int g = 0; g < 2; g++) begin
            first_low[g] = -1; last_low[g] = -1; low_cnt[g] = 0; idle_bad[g] = 0;
            rise_bad[g] = 0; nbits[g] = 0; done_cnt[g] = 0; done_all[g] = 0;
            done_cyc[g] = -1; ready_back[g] = -1; next_low[g] = -1;
            ended[g] = 1'b0; prev_sclk[g] = sclk[g]; cap[g] = '0;
        end
        i_data  = data;
        i_len   = len;
        i_start = 1'b1;
        tick();
        lim = (rst_at >= 0) ? rst_at + 6 : 4 * eff + 12;
        for (int c = 1; c <= lim; c++) begin
            i_start = hold || c == poke;
            if (c == poke) i_data = ~data;
            i_reset = rst_at >= 0 && c == rst_at;
            if (rst_at >= 0 && c == rst_at + 1)
                for (int g = 0; g < 2; g++)
                    check_i($sformatf("%s h%0d reset_outs", tag, hv(g)), outs(g), 5'b10010);
            for (int g = 0; g < 2; g++) begin
                h = hv(g);
                if (done[g]) done_all[g]++;
                if (!ended[g]) begin
                    if (!csb[g]) begin
                        if (first_low[g] < 0) first_low[g] = c;
                        last_low[g] = c;
                        low_cnt[g]++;
                    end else if (sclk[g] || mosi[g]) idle_bad[g]++;
                    if (sclk[g] && !prev_sclk[g]) begin
                        if (c != 1 + h + 2 * h * nbits[g]) rise_bad[g]++;
                        cap[g] = {cap[g][72:0], mosi[g]};
                        nbits[g]++;
                    end
                    if (done[g]) begin
                        done_cnt[g]++;
                        done_cyc[g] = c;
                    end
                    if (ready[g]) begin
                        ready_back[g] = c;
                        ended[g] = 1'b1;
                    end
                end else if (next_low[g] < 0 && !csb[g]) next_low[g] = c;
                prev_sclk[g] = sclk[g];
            end
            tick();
        end
        i_start = 1'b0;
        i_reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            h = hv(g);
            if (rst_at >= 0) begin
                check_i($sformatf("%s h%0d no_done", tag, h), done_all[g], 0);
            end else begin
                dexp = (eff > 0) ? 2 * h + 2 * h * eff : 1;
                check_w($sformatf("%s h%0d bits", tag, h), cap[g], expw);
                check_i($sformatf("%s h%0d nbits", tag, h), nbits[g], eff);
                check_i($sformatf("%s h%0d rise_misplaced", tag, h), rise_bad[g], 0);
                check_i($sformatf("%s h%0d idle_activity", tag, h), idle_bad[g], 0);
                check_i($sformatf("%s h%0d csb_low_cycles", tag, h), low_cnt[g], (eff > 0) ? h + 2 * h * eff : 0);
                check_i($sformatf("%s h%0d csb_first_low", tag, h), first_low[g], (eff > 0) ? 1 : -1);
                check_i($sformatf("%s h%0d done_pulses", tag, h), done_cnt[g], 1);
                check_i($sformatf("%s h%0d done_cycle", tag, h), done_cyc[g], dexp);
                check_i($sformatf("%s h%0d ready_cycle", tag, h), ready_back[g], dexp + 1);
                if (hold)
                    check_i($sformatf("%s h%0d csb_gap", tag, h), next_low[g] - last_low[g] - 1, h + 1);
            end
        end
    endtask

    initial begin
        int bad[2];
        repeat (3) tick();
        i_reset = 1'b0;
        tick();
        for (int g = 0; g < 2; g++) check_i($sformatf("reset_state h%0d", hv(g)), outs(g), 5'b10010);
        bad = '{0, 0};
        repeat (20) begin
            for (int g = 0; g < 2; g++) if (outs(g) != 5'b10010) bad[g]++;
            tick();
        end
        for (int g = 0; g < 2; g++) check_i($sformatf("idle h%0d", hv(g)), bad[g], 0);
        run_frame("a5", 74'hA5, 7'd8, 1'b0, -1, -1);
        run_frame("alt74", {37{2'b10}}, 7'd74, 1'b0, -1, -1);
        run_frame("len0", 74'h3F, 7'd0, 1'b0, -1, -1);
        run_frame("len100", rnd74(), 7'd100, 1'b0, -1, -1);
        run_frame("poke", rnd74(), 7'd8, 1'b0, 6, -1);
        run_frame("hold", rnd74(), 7'd5, 1'b1, -1, -1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        tick();
        run_frame("rst", rnd74(), 7'd8, 1'b0, -1, 12);
        run_frame("after_rst", rnd74(), 7'd8, 1'b0, -1, -1);
        for (int r = 0; r < 6; r++)
            run_frame($sformatf("rnd%0d", r), rnd74(), 7'($urandom_range(0, 100)), 1'b0, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
